// File: rtl/msk_unmask_pkg.sv
// Shared types and helpers for the serial share-recombination datapath.
package msk_unmask_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FOLD,
    OUT
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msk_fold_reg.sv
// Accumulator register folding one share per enabled clock: D = acc ^ share.
module msk_fold_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] share,
  output logic [W-1:0] sum
);

  logic [W-1:0] acc_q, acc_d;

  // The only XOR touching share-derived data; sum is also the final result tap.
  assign sum = acc_q ^ share;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/msk_unmask_serial.sv
// Serial unmasking: folds one share per clock into an accumulator, exposes only the result.
module msk_unmask_serial
  import msk_unmask_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [count*d-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [count-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned CW = clog2_min1(d);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [count-1:0] shr_q [d];
  logic [count-1:0] shr_d [d];
  logic [count-1:0] out_data_q, out_data_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [count-1:0] in_share [d];
  logic [count-1:0] sel_share;
  logic [count-1:0] fold_sum;
  logic             accept, fold_last, out_fire;

  always_comb begin
    for (int unsigned j = 0; j < d; j++) begin
      for (int unsigned k = 0; k < count; k++) begin
        in_share[j][k] = in_data[k*d + j];
      end
    end
  end

  assign accept    = (state_q == IDLE) && in_valid;
  assign fold_last = (state_q == FOLD) && (cnt_q == CW'(d - 1));
  assign out_fire  = (state_q == OUT) && out_ready;

  // Share 0 enters straight from the input; later shares come from the share register.
  always_comb begin
    sel_share = shr_q[cnt_q];
    if (state_q == IDLE) begin
      sel_share = in_share[0];
    end
  end

  msk_fold_reg #(
    .W(count)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fold_last || out_fire),
    .en    (accept || (state_q == FOLD)),
    .share (sel_share),
    .sum   (fold_sum)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shr_d      = shr_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int unsigned j = 1; j < d; j++) begin
            shr_d[j] = in_share[j];
          end
          cnt_d = CW'(1);
          if (d == 1) begin
            out_data_d = fold_sum;
            state_d    = OUT;
          end else begin
            state_d = FOLD;
          end
        end
      end
      FOLD: begin
        shr_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;
        if (fold_last) begin
          out_data_d = fold_sum;
          cnt_d      = '0;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_data_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      for (int unsigned j = 0; j < d; j++) begin
        shr_q[j] <= '0;
      end
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shr_q       <= shr_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_msk_unmask_serial.sv
// Bench for msk_unmask_serial: directed scenarios plus randomized runs against a timing/XOR model.
module tb_msk_unmask_serial;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  // A: d=2,count=4   B: d=3,count=1   C: d=1,count=2   D: d=4,count=8
  logic [7:0]  a_in;  logic a_iv, a_ir, a_ov, a_or;  logic [3:0] a_od;
  logic [2:0]  b_in;  logic b_iv, b_ir, b_ov, b_or;  logic [0:0] b_od;
  logic [1:0]  c_in;  logic c_iv, c_ir, c_ov, c_or;  logic [1:0] c_od;
  logic [31:0] d_in;  logic d_iv, d_ir, d_ov, d_or;  logic [7:0] d_od;
  // Random-stress instances: index 0 d=2, 1 d=3, 2 d=5, all count=8
  logic [39:0] r_in [3];
  logic [2:0]  r_iv, r_or, r_ir, r_ov;
  logic [7:0]  r_od [3];

  msk_unmask_serial #(.d(2), .count(4)) u_a (.clk(clk), .rst_n(rst_n), .in_data(a_in), .in_valid(a_iv),
    .in_ready(a_ir), .out_data(a_od), .out_valid(a_ov), .out_ready(a_or));
  msk_unmask_serial #(.d(3), .count(1)) u_b (.clk(clk), .rst_n(rst_n), .in_data(b_in), .in_valid(b_iv),
    .in_ready(b_ir), .out_data(b_od), .out_valid(b_ov), .out_ready(b_or));
  msk_unmask_serial #(.d(1), .count(2)) u_c (.clk(clk), .rst_n(rst_n), .in_data(c_in), .in_valid(c_iv),
    .in_ready(c_ir), .out_data(c_od), .out_valid(c_ov), .out_ready(c_or));
  msk_unmask_serial #(.d(4), .count(8)) u_d (.clk(clk), .rst_n(rst_n), .in_data(d_in), .in_valid(d_iv),
    .in_ready(d_ir), .out_data(d_od), .out_valid(d_ov), .out_ready(d_or));
  msk_unmask_serial #(.d(2), .count(8)) u_r2 (.clk(clk), .rst_n(rst_n), .in_data(r_in[0][15:0]),
    .in_valid(r_iv[0]), .in_ready(r_ir[0]), .out_data(r_od[0]), .out_valid(r_ov[0]), .out_ready(r_or[0]));
  msk_unmask_serial #(.d(3), .count(8)) u_r3 (.clk(clk), .rst_n(rst_n), .in_data(r_in[1][23:0]),
    .in_valid(r_iv[1]), .in_ready(r_ir[1]), .out_data(r_od[1]), .out_valid(r_ov[1]), .out_ready(r_or[1]));
  msk_unmask_serial #(.d(5), .count(8)) u_r5 (.clk(clk), .rst_n(rst_n), .in_data(r_in[2][39:0]),
    .in_valid(r_iv[2]), .in_ready(r_ir[2]), .out_data(r_od[2]), .out_valid(r_ov[2]), .out_ready(r_or[2]));

  initial forever #5 clk = ~clk;

  // Plain bit = XOR of all its shares; share s of bit k sits at k*dd+s.
  function automatic logic [7:0] unmask(input logic [39:0] v, input int unsigned dd, input int unsigned c);
    logic [7:0] r;
    r = '0;
    for (int unsigned s = 0; s < dd; s++)
      for (int unsigned k = 0; k < c; k++)
        r[k] = r[k] ^ v[k*dd + s];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_ir); end
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_ov); end
    checks++; if (d_od !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", d_od); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({a_ir, b_ir, c_ir, d_ir} !== 4'b1111) begin errors++; $display("FAIL post_reset_ready: got %b expected 1111", {a_ir, b_ir, c_ir, d_ir}); end
    checks++; if ({a_ov, b_ov, c_ov, d_ov} !== 4'b0000) begin errors++; $display("FAIL post_reset_valid: got %b expected 0000", {a_ov, b_ov, c_ov, d_ov}); end
  endtask

  task automatic test_d2_basic();
    a_in = 8'h6C; a_iv = 1'b1; a_or = 1'b0;
    @(negedge clk);
    a_iv = 1'b0;
    checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL d2_busy_ready: got %b expected 0", a_ir); end
    checks++; if ({a_ov, a_od} !== 5'b0_0000) begin errors++; $display("FAIL d2_fold_out: got %b expected 00000", {a_ov, a_od}); end
    @(negedge clk);
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL d2_valid: got %b expected 1", a_ov); end
    checks++; if (a_od !== 4'b1100) begin errors++; $display("FAIL d2_data: got %b expected 1100", a_od); end
    a_or = 1'b1;
    @(negedge clk);
    a_or = 1'b0;
    checks++; if ({a_ir, a_ov, a_od} !== 6'b10_0000) begin errors++; $display("FAIL d2_release: got %b expected 100000", {a_ir, a_ov, a_od}); end
  endtask

  task automatic test_d3_ignore_input();
    b_in = 3'b111; b_iv = 1'b1; b_or = 1'b0;
    @(negedge clk);
    b_in = 3'b010;
    checks++; if ({b_ir, b_ov, b_od} !== 3'b000) begin errors++; $display("FAIL d3_fold1: got %b expected 000", {b_ir, b_ov, b_od}); end
    @(negedge clk);
    checks++; if ({b_ir, b_ov} !== 2'b00) begin errors++; $display("FAIL d3_fold2: got %b expected 00", {b_ir, b_ov}); end
    b_iv = 1'b0;
    @(negedge clk);
    checks++; if ({b_ir, b_ov} !== 2'b01) begin errors++; $display("FAIL d3_valid: got %b expected 01", {b_ir, b_ov}); end
    checks++; if (b_od !== 1'b1) begin errors++; $display("FAIL d3_data: got %b expected 1", b_od); end
    b_or = 1'b1;
    @(negedge clk);
    b_or = 1'b0;
    checks++; if ({b_ir, b_ov, b_od} !== 3'b100) begin errors++; $display("FAIL d3_release: got %b expected 100", {b_ir, b_ov, b_od}); end
  endtask

  task automatic test_d1_direct();
    c_in = 2'b10; c_iv = 1'b1; c_or = 1'b0;
    @(negedge clk);
    c_iv = 1'b0;
    checks++; if ({c_ir, c_ov} !== 2'b01) begin errors++; $display("FAIL d1_valid: got %b expected 01", {c_ir, c_ov}); end
    checks++; if (c_od !== 2'b10) begin errors++; $display("FAIL d1_data: got %b expected 10", c_od); end
    c_or = 1'b1;
    @(negedge clk);
    c_or = 1'b0;
    checks++; if ({c_ir, c_ov, c_od} !== 4'b1000) begin errors++; $display("FAIL d1_release: got %b expected 1000", {c_ir, c_ov, c_od}); end
  endtask

  task automatic test_backpressure();
    a_in = 8'h93; a_iv = 1'b1; a_or = 1'b0;
    @(negedge clk);
    a_in = 8'h5A;
    checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b expected 0", a_ir); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if ({a_ir, a_ov, a_od} !== 6'b01_1100) begin errors++; $display("FAIL bp_hold: cycle %0d got %b expected 011100", i, {a_ir, a_ov, a_od}); end
    end
    a_or = 1'b1;
    @(negedge clk);
    a_or = 1'b0;
    checks++; if ({a_ir, a_ov, a_od} !== 6'b10_0000) begin errors++; $display("FAIL bp_release: got %b expected 100000", {a_ir, a_ov, a_od}); end
    @(negedge clk);
    a_iv = 1'b0;
    checks++; if ({a_ir, a_ov} !== 2'b00) begin errors++; $display("FAIL bp_next_accept: got %b expected 00", {a_ir, a_ov}); end
    @(negedge clk);
    checks++; if ({a_ov, a_od} !== 5'b1_1111) begin errors++; $display("FAIL bp_next_data: got %b expected 11111", {a_ov, a_od}); end
    a_or = 1'b1;
    @(negedge clk);
    a_or = 1'b0;
  endtask

  task automatic test_reset_midfold();
    logic [31:0] v;
    logic [7:0]  e;
    d_in = 32'hDEADBEEF; d_iv = 1'b1; d_or = 1'b0;
    @(posedge clk);
    #1 d_iv = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({d_ir, d_ov, d_od} !== 10'b10_0000_0000) begin errors++; $display("FAIL rst_mid_ports: got %b expected 1000000000", {d_ir, d_ov, d_od}); end
    checks++; if (u_d.u_acc.acc_q !== 8'h00) begin errors++; $display("FAIL rst_mid_acc: got %h expected 00", u_d.u_acc.acc_q); end
    checks++; if (u_d.cnt_q !== 2'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", u_d.cnt_q); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (u_d.shr_q[j] !== 8'h00) begin errors++; $display("FAIL rst_mid_shr: slot %0d got %h expected 00", j, u_d.shr_q[j]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = $urandom;
    e = unmask({8'h00, v}, 4, 8);
    d_in = v; d_iv = 1'b1;
    @(negedge clk);
    d_iv = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (d_ov !== 1'b0) begin errors++; $display("FAIL rst_after_early: got %b expected 0", d_ov); end
    @(negedge clk);
    checks++; if ({d_ov, d_od} !== {1'b1, e}) begin errors++; $display("FAIL rst_after_data: got %b_%h expected 1_%h", d_ov, d_od, e); end
    d_or = 1'b1;
    @(negedge clk);
    d_or = 1'b0;
  endtask

  // Model: a sharing is accepted only when nothing is in flight, appears dd-1 edges later,
  // and leaves on out_ready; data must equal the XOR of its shares.
  task automatic test_random(input int unsigned idx, input int unsigned dd, input int unsigned n);
    logic [7:0]  expq [$];
    logic [39:0] v;
    logic [7:0]  exp_od;
    int unsigned sent, got, cyc, wait_c;
    bit          busy;
    sent = 0; got = 0; cyc = 0; wait_c = 0; busy = 1'b0;
    while ((sent < n || got < n) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      exp_od = (busy && wait_c == 0 && expq.size() > 0) ? expq[0] : 8'h00;
      checks++; if (r_ir[idx] !== !busy) begin errors++; $display("FAIL rnd_ready d=%0d cyc %0d: got %b expected %b", dd, cyc, r_ir[idx], !busy); end
      checks++; if (r_ov[idx] !== (busy && wait_c == 0)) begin errors++; $display("FAIL rnd_valid d=%0d cyc %0d: got %b expected %b", dd, cyc, r_ov[idx], busy && wait_c == 0); end
      checks++; if (r_od[idx] !== exp_od) begin errors++; $display("FAIL rnd_data d=%0d cyc %0d: got %h expected %h", dd, cyc, r_od[idx], exp_od); end
      v = {$urandom, $urandom};
      v = v & ((40'd1 << (8*dd)) - 40'd1);
      r_in[idx] = v;
      r_iv[idx] = (sent < n) && ($urandom_range(0, 1) == 1);
      r_or[idx] = ($urandom_range(0, 3) != 0);
      if (busy && wait_c == 0) begin
        if (r_or[idx]) begin
          void'(expq.pop_front());
          got++;
          busy = 1'b0;
        end
      end else if (busy) begin
        wait_c--;
      end else if (r_iv[idx]) begin
        expq.push_back(unmask(v, dd, 8));
        sent++;
        busy = 1'b1;
        wait_c = dd - 1;
      end
    end
    r_iv[idx] = 1'b0;
    r_or[idx] = 1'b0;
    checks++; if (sent != n || got != n || expq.size() != 0) begin errors++; $display("FAIL rnd_complete d=%0d: sent %0d got %0d pending %0d expected %0d/%0d/0", dd, sent, got, expq.size(), n, n); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_in = '0; a_iv = 0; a_or = 0;
    b_in = '0; b_iv = 0; b_or = 0;
    c_in = '0; c_iv = 0; c_or = 0;
    d_in = '0; d_iv = 0; d_or = 0;
    for (int i = 0; i < 3; i++) r_in[i] = '0;
    r_iv = '0; r_or = '0;
    test_reset();
    test_d2_basic();
    test_d3_ignore_input();
    test_d1_direct();
    test_backpressure();
    test_reset_midfold();
    test_random(0, 2, 1000);
    test_random(1, 3, 1000);
    test_random(2, 5, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
